// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: data width, default bit
// period and the receiver state encoding.
// Configuration macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1 frame).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;   // 10 MHz clock / 115200 baud

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

   // Even parity holds when data bits plus parity bit contain an even number of ones.
   function automatic logic even_parity_ok(input logic [UART_DATA_W-1:0] i_data,
                                           input logic                   i_par);
      return ~(^{i_data, i_par});
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head entry and overrun reporting.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push          write request (ignored when full unless a pop occurs)
//   i_push_data     write data
//   i_pop           read request (ignored when empty)
//   o_head          registered head entry, stable until popped
//   o_valid         FIFO not empty
//   o_count         number of stored entries
//   o_overrun       one-cycle pulse when a push is dropped because full
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 4,   // power of two, >= 2
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overrun
);

   localparam int            AW         = $clog2(DEPTH);
   localparam int            CW         = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_head;
   logic             r_overrun;

   logic             w_empty;
   logic             w_full;
   logic             w_do_pop;
   logic             w_do_push;
   logic [AW-1:0]    w_rd_next;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_COUNT);
   assign w_do_pop  = i_pop & ~w_empty;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign w_do_push = i_push & (~w_full | w_do_pop);
   // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
   assign w_rd_next = r_rd_ptr + 1'b1;

   // NOTE: the storage array is deliberately left without reset; the pointers
   // and count decide which entries are meaningful, and a reset-free array
   // maps onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_head    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= w_rd_next;

         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;   // none, or push and pop together: count unchanged
         endcase

         r_overrun <= i_push & w_full & ~w_do_pop;

         // Head register tracks mem[rd_ptr]. When full, the slot being
         // written is the one being popped, never rd_ptr+1 (DEPTH >= 2).
         if (w_do_pop) begin
            if (r_count > ONE_COUNT) r_head <= r_mem[w_rd_next];
            else if (w_do_push)      r_head <= i_push_data;
         end else if (w_do_push && w_empty) begin
            r_head <= i_push_data;
         end
      end
   end

   assign o_head    = r_head;
   assign o_valid   = ~w_empty;
   assign o_count   = r_count;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a
// small receive FIFO.
// Configuration macro: UART_RX_PARITY_EN.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx           asynchronous serial input, idle high
//   rx_data      head-of-FIFO byte, valid while rx_valid = 1
//   rx_valid     FIFO not empty
//   rx_ready     consumer pops the head byte when rx_valid & rx_ready
//   frame_err    one-cycle pulse on a low stop bit
//   overrun      one-cycle pulse when a good byte is dropped (FIFO full)
//   parity_err   one-cycle pulse on parity mismatch (0 in 8N1 builds)
//   fifo_count   number of stored bytes
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   output logic [UART_DATA_W-1:0]        rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          parity_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam int               BIT_W    = $clog2(UART_DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_W - 1);

   // Synchronizer plus one history flop for edge detection; all idle high.
   logic                   r_rx_meta;
   logic                   r_rx_sync;
   logic                   r_rx_prev;

   rx_state_e              r_state;
   logic [CNT_W-1:0]       r_clk_cnt;
   logic [BIT_W-1:0]       r_bit_idx;
   logic [UART_DATA_W-1:0] r_shift;
   logic                   r_push;
   logic                   r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic                   r_par_bit;
   logic                   r_parity_err;
`endif

   logic                   w_fall;
   logic                   w_bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_fall    = r_rx_prev & ~r_rx_sync;
   assign w_bit_end = (r_clk_cnt == LAST_CNT);

   // Receiver FSM. The counter restarts at every sample point, so once the
   // start bit is re-checked mid-bit, every later sample lands mid-bit too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_clk_cnt    <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_push       <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_clk_cnt <= '0;
               if (w_fall) r_state <= ST_START;
            end

            ST_START: begin
               if (r_clk_cnt == HALF_CNT) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= '0;
                  // Line back high at mid-start: treat as a glitch.
                  r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_rx_sync, r_shift[UART_DATA_W-1:1]};   // LSB first
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_par_bit <= r_rx_sync;
                  r_state   <= ST_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
                     if (even_parity_ok(r_shift, r_par_bit)) r_push <= 1'b1;
                     else                                    r_parity_err <= 1'b1;
`else
                     r_push <= 1'b1;
`endif
                     // Leave at mid-stop so the next start edge is not missed.
                     r_state <= ST_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_BREAK;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            ST_BREAK: begin
               if (r_rx_sync) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // r_shift is untouched between the stop sample and the next DATA state,
   // so it can feed the FIFO directly on the push cycle.
   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (r_push),
      .i_push_data (r_shift),
      .i_pop       (rx_ready),
      .o_head      (rx_data),
      .o_valid     (rx_valid),
      .o_count     (fifo_count),
      .o_overrun   (overrun)
   );

   assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. Expected bytes go into a queue as
// frames are sent; a monitor pops and compares on every rx_valid & rx_ready
// and counts error pulses for comparison against expected pulse counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int CPB   = 87;
   localparam int DEPTH = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      rx;
   logic                      rx_ready;
   logic [7:0]                rx_data;
   logic                      rx_valid;
   logic                      frame_err;
   logic                      overrun;
   logic                      parity_err;
   logic [$clog2(DEPTH):0]    fifo_count;

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] exp_q[$];
   int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
   int         obs_fe = 0, obs_ov = 0, obs_pe = 0;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   task automatic monitor();
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (frame_err)  obs_fe++;
            if (overrun)    obs_ov++;
            if (parity_err) obs_pe++;
            if (rx_valid && rx_ready) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  n_bad++;
                  $display("FAIL sb_unexpected: got 0x%02h want no byte", rx_data);
               end else begin
                  exp = exp_q.pop_front();
                  check("sb_data", {24'h0, rx_data}, {24'h0, exp});
               end
            end
         end
      end
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_frame_err"},  obs_fe, exp_fe);
      check({tag, "_overrun"},    obs_ov, exp_ov);
      check({tag, "_parity_err"}, obs_pe, exp_pe);
   endtask

   // Drive rx to v for n clock periods; changes land 1 ns after a rising edge.
   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic [7:0] d, input logic par,
                           input logic stop_v, input int stop_n);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      hold(par, CPB);
`else
      if (par === 1'bx) hold(1'b1, 0);   // parity bit is not on the wire in 8N1
`endif
      hold(stop_v, stop_n);
      rx = 1'b1;
   endtask

   // Correct frame: even parity bit makes the total number of ones even.
   task automatic send_byte(input logic [7:0] d);
      send_raw(d, ^d, 1'b1, CPB);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rx       = 1'b1;
      rx_ready = 1'b1;
      rst      = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_rx_data",    {24'h0, rx_data}, 32'h00);
      check("rst_rx_valid",   rx_valid,   0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_frame_err",  frame_err,  0);
      check("rst_overrun",    overrun,    0);
      check("rst_parity_err", parity_err, 0);
      hold(1'b1, 10);

      // Single good byte, consumer always ready
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      wait_drain("a5_drain", 200);
      check_errs("a5");

      // Short low glitch shorter than half a bit: rejected silently
      hold(1'b0, 20);
      hold(1'b1, 200);
      check("glitch_count", fifo_count, 0);
      check("glitch_valid", rx_valid,   0);
      check_errs("glitch");
      exp_q.push_back(8'h96);
      send_byte(8'h96);
      wait_drain("post_glitch_drain", 200);

      // Stop bit held low: framing error, byte discarded, then recovery
      send_raw(8'h3C, ^8'h3C, 1'b0, 200);
      exp_fe++;
      hold(1'b1, 20);
      check("fe_count", fifo_count, 0);
      check_errs("fe");
      exp_q.push_back(8'h11);
      send_byte(8'h11);
      wait_drain("fe_next_drain", 200);

      // Fill the FIFO with no consumer; fifth byte overruns
      rx_ready = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         exp_q.push_back(8'(b));
         send_byte(8'(b));
      end
      hold(1'b1, 5);
      check("full_count", fifo_count, 4);
      check_errs("full_pre_ov");
      send_byte(8'h05);
      exp_ov++;
      hold(1'b1, 5);
      check("ov_count", fifo_count, 4);
      check("ov_head",  {24'h0, rx_data}, 32'h01);
      check("ov_valid", rx_valid, 1);
      check_errs("ov");
      rx_ready = 1'b1;
      wait_drain("ov_drain", 50);
      check("ov_drained_count", fifo_count, 0);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity bit 0 is wrong, 1 is right
      send_raw(8'h07, 1'b0, 1'b1, CPB);
      exp_pe++;
      hold(1'b1, 5);
      check("pe_count", fifo_count, 0);
      check_errs("pe");
      exp_q.push_back(8'h07);
      send_raw(8'h07, 1'b1, 1'b1, CPB);
      wait_drain("pe_good_drain", 200);
`endif

      // Reset in the middle of data bit 4 of 0xFF, then a clean byte
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(1'b1, CPB);
      hold(1'b1, 40);
      rst = 1'b1;
      hold(1'b1, 3);
      rst = 1'b0;
      hold(1'b1, 20);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_valid", rx_valid,   0);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A);
      wait_drain("mid_rst_drain", 200);
      check_errs("mid_rst");

      hold(1'b1, 20);
      check("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clk cycles per UART bit (10 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data  output  8  head-of-FIFO byte; valid only while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts the head byte when rx_valid & rx_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored bytes.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer; all detection uses the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-015 IDLE SHALL go to START on a synchronized high-to-low transition and clear the bit-period counter.
REQ-016 START SHALL re-sample at count CLKS_PER_BIT/2 (integer); low goes to DATA, high returns to IDLE (glitch rejected, no pulse).
REQ-017 DATA SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, LSB first, then go to PARITY or STOP.
REQ-018 PARITY SHALL sample one bit and check even parity over the 8 data bits plus the parity bit.
REQ-019 STOP SHALL sample one bit; high completes the frame; low pulses frame_err, discards the byte and goes to BREAK.
REQ-020 BREAK SHALL wait for synchronized rx high, then go to IDLE.
REQ-021 A completed frame with parity mismatch SHALL pulse parity_err and SHALL NOT be written to the FIFO.
REQ-022 A good frame SHALL be written to the FIFO on the cycle after the stop-bit sample; rx_valid is visible one cycle later.
REQ-023 On a good frame with the FIFO full and no pop that cycle, the byte SHALL be dropped, overrun pulses, and stored contents are unchanged.
REQ-024 On a simultaneous push and pop, including when full, both SHALL take effect and fifo_count is unchanged.
REQ-025 The FIFO SHALL be first-in first-out; read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 rx_ready while rx_valid=0 SHALL be ignored.
REQ-027 rx_data SHALL be the registered head entry, stable until popped.
REQ-028 The FSM SHALL return to IDLE after every frame outcome and resume reception with no idle gap beyond the stop bit.

Reset
REQ-029 rst SHALL set the FSM to IDLE, clear counters and pointers, set both synchronizer flops to 1, and set rx_valid, frame_err, overrun, parity_err and fifo_count to 0; rx_data resets to 0x00.
REQ-030 rst asserted mid-frame SHALL abort the frame with no push and no error pulse.

Configuration
REQ-031 UART_RX_PARITY_EN SHALL be the only configuration macro.
REQ-032 With UART_RX_PARITY_EN defined, the frame SHALL be 8E1: the PARITY state is present and parity_err is live.
REQ-033 Without UART_RX_PARITY_EN, the frame SHALL be 8N1: the PARITY state is absent and parity_err is constant 0.

Structure
REQ-034 The shared package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT constant and UART_DATA_W = 8.
REQ-035 The FIFO SHALL be a separate sub-module, sync_fifo, instantiated once.

Verification
REQ-036 Send 0xA5 (8N1, 87 clks/bit), rx_ready=1 -> rx_valid pulses with rx_data=0xA5; no error pulses.
REQ-037 rx low for 20 clks, then high -> no push, no error pulse, FSM back in IDLE.
REQ-038 Send 0x3C with stop bit held low for 200 clks -> one frame_err pulse, fifo_count=0; the next 0x11 is received correctly.
REQ-039 rx_ready=0, send 0x01..0x05 -> fifo_count=4, one overrun pulse at byte 5; drain yields 0x01,0x02,0x03,0x04.
REQ-040 Macro defined, send 0x07 with parity bit 0 -> one parity_err pulse, no push; 0x07 with parity bit 1 -> rx_data=0x07.
REQ-041 Assert rst during data bit 4 of 0xFF, release, send 0x5A -> only 0x5A is received; no error pulses.
